// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and the write/read channel FSM states.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_VALID
  } rd_state_t;

endpackage

// File: rtl/axil_strb_merge.sv
// Byte-enable merge: each byte lane takes the new word where its strobe is set,
// otherwise keeps the old word.
module axil_strb_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  strb,
  output logic [31:0] merged_word
);

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign merged_word[8*k +: 8] = strb[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
  end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers, with independent write and
// read FSMs, byte strobes, and a per-register update strobe.
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDR_WIDTH-1:0]    awaddr,
  input  logic [2:0]               awprot,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [ADDR_WIDTH-1:0]    araddr,
  input  logic [2:0]               arprot,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [32*NUM_REGS-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      reg_wr
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  logic [31:0]          regs [NUM_REGS];
  wr_state_t            wr_state, wr_state_next;
  logic                 wr_go, wr_go_next;
  logic [IDX_W-1:0]     aw_idx;
  logic [31:0]          w_data;
  logic [3:0]           w_strb;
  logic                 aw_hs, w_hs;
  logic [31:0]          merged;
  rd_state_t            rd_state, rd_state_next;
  logic                 ar_hs;
  logic [31:0]          rdata_q;
  logic [NUM_REGS-1:0]  reg_wr_q;
  logic                 unused_bits;

  assign unused_bits = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

  // wr_go marks "address and data both latched": the write commits on the next
  // edge, and no further AW/W may be accepted in the meantime.
  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    if (!reset && !wr_go) begin
      case (wr_state)
        WR_IDLE:    begin awready = 1'b1; wready = 1'b1; end
        WR_HAVE_AW: wready  = 1'b1;
        WR_HAVE_W:  awready = 1'b1;
        default:    ;
      endcase
    end
  end

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  always_comb begin
    wr_state_next = wr_state;
    wr_go_next    = wr_go;
    case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_state_next = WR_HAVE_AW;
          wr_go_next    = 1'b1;
        end else if (aw_hs) begin
          wr_state_next = WR_HAVE_AW;
        end else if (w_hs) begin
          wr_state_next = WR_HAVE_W;
        end
      end
      WR_HAVE_AW: begin
        if (wr_go) begin
          wr_state_next = WR_RESP;
          wr_go_next    = 1'b0;
        end else if (w_hs) begin
          wr_go_next = 1'b1;
        end
      end
      WR_HAVE_W: begin
        if (wr_go) begin
          wr_state_next = WR_RESP;
          wr_go_next    = 1'b0;
        end else if (aw_hs) begin
          wr_go_next = 1'b1;
        end
      end
      WR_RESP: begin
        if (bready) wr_state_next = WR_IDLE;
      end
      default: wr_state_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state <= WR_IDLE;
      wr_go    <= 1'b0;
      aw_idx   <= '0;
      w_data   <= '0;
      w_strb   <= '0;
    end else begin
      wr_state <= wr_state_next;
      wr_go    <= wr_go_next;
      if (aw_hs) aw_idx <= awaddr[ADDR_WIDTH-1:2];
      if (w_hs) begin
        w_data <= wdata;
        w_strb <= wstrb;
      end
    end
  end

  axil_strb_merge u_merge (
    .old_word    (regs[aw_idx]),
    .new_word    (w_data),
    .strb        (w_strb),
    .merged_word (merged)
  );

  // A zero strobe still counts as a write: the strobe pulses even though no lane changes.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_wr_q <= '0;
    end else begin
      reg_wr_q <= '0;
      if (wr_go) begin
        regs[aw_idx]     <= merged;
        reg_wr_q[aw_idx] <= 1'b1;
      end
    end
  end

  assign arready = !reset && (rd_state == RD_IDLE);
  assign ar_hs   = arvalid && arready;

  always_comb begin
    rd_state_next = rd_state;
    case (rd_state)
      RD_IDLE:  if (ar_hs) rd_state_next = RD_VALID;
      RD_VALID: if (rready) rd_state_next = RD_IDLE;
      default:  rd_state_next = RD_IDLE;
    endcase
  end

  // Sampling regs before this edge's write lands gives read-before-write ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state <= RD_IDLE;
      rdata_q  <= '0;
    end else begin
      rd_state <= rd_state_next;
      if (ar_hs) rdata_q <= regs[araddr[ADDR_WIDTH-1:2]];
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regq
    assign reg_q[32*i +: 32] = regs[i];
  end

  assign bvalid = !reset && (wr_state == WR_RESP);
  assign rvalid = !reset && (rd_state == RD_VALID);
  assign bresp  = RESP_OKAY;
  assign rresp  = RESP_OKAY;
  assign rdata  = rdata_q;
  assign reg_wr = reg_wr_q;

endmodule
